// File: rtl/epsilon_stream_gen.sv
// Epsilon bit-stream source for the approximate-entropy core: serializes host
// bytes (MSB first) or an internal 16-bit LFSR into framed SEQ_LEN-bit sequences.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; mode sampled with start
//   S_LOAD  | byte mode: byte_rdy high, waiting for the next host byte
//   S_SHIFT | epsilon_vld high; one bit leaves per epsilon_rdy
//   S_GAP   | GAP_CYCLES idle cycles after a sequence, busy still high
module epsilon_stream_gen #(
    parameter int          SEQ_LEN    = 128,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [7:0]  byte_dat,
    input  logic        byte_vld,
    output logic        byte_rdy,
    output logic        epsilon_rsc_dat,
    output logic        epsilon_vld,
    input  logic        epsilon_rdy,
    output logic        sof,
    output logic        eof,
    output logic        busy,
    output logic [15:0] bit_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    localparam logic [15:0] LAST_IDX = 16'(SEQ_LEN - 1);
    localparam logic [15:0] GAP_INIT = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  bits_left_q, bits_left_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] gap_q, gap_d;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            shreg_q     <= 8'h00;
            bits_left_q <= 4'd0;
            lfsr_q      <= LFSR_SEED;
            bit_cnt_q   <= 16'd0;
            gap_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            lfsr_q      <= lfsr_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        lfsr_d      = lfsr_q;
        bit_cnt_d   = bit_cnt_q;
        gap_d       = gap_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    bit_cnt_d = 16'd0;
                    state_d   = mode ? S_SHIFT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (byte_vld) begin
                    shreg_d     = byte_dat;
                    bits_left_d = 4'd8;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (epsilon_rdy) begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                    if (mode_q) begin
                        lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                    end else begin
                        shreg_d     = {shreg_q[6:0], 1'b0};
                        bits_left_d = bits_left_q - 4'd1;
                    end
                    // A short final byte simply abandons its remaining low bits here.
                    if (bit_cnt_q == LAST_IDX) begin
                        bit_cnt_d = 16'd0;
                        if (GAP_CYCLES == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_INIT;
                        end
                    end else if (!mode_q && bits_left_q == 4'd1) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 16'd0) state_d = S_IDLE;
                else                gap_d   = gap_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Lock-up guard; cannot trigger from a nonzero seed.
        if (lfsr_q == 16'd0) lfsr_d = LFSR_SEED;
    end

    assign byte_rdy        = (state_q == S_LOAD);
    assign epsilon_vld     = (state_q == S_SHIFT);
    assign epsilon_rsc_dat = epsilon_vld & (mode_q ? lfsr_q[0] : shreg_q[7]);
    assign sof             = epsilon_vld && (bit_cnt_q == 16'd0);
    assign eof             = epsilon_vld && (bit_cnt_q == LAST_IDX);
    assign busy            = (state_q != S_IDLE);
    assign bit_cnt         = bit_cnt_q;

endmodule
